stack_cpu_core: RTL and testbench



---
 rtl/stack_cpu_core.sv | 195 +++++++++++++++++++
 tb/tb_stack_cpu_core.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/stack_cpu_core.sv
// Multi-cycle 8-bit stack-machine tile: FETCH/EXEC/RETIRE sequencer, loadable program store, 8-deep operand stack, 256x8 data memory.
// Latency: 3 clocks per instruction, committed on the EXEC edge; no backpressure, a fault or HALT parks the core in RETIRE until reset.
module stack_cpu_core #(
    parameter int DATA_LEN    = 8,
    parameter int ADDR_LEN    = 8,
    parameter int MEM_SIZE    = 256,
    parameter int INST_CAP    = 20,
    parameter int INST_LEN    = 12,
    parameter int STACK_DEPTH = 8,
    localparam int PW = $clog2(INST_CAP) + 1,
    localparam int SW = $clog2(STACK_DEPTH),
    localparam int CW = SW + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  prog_we,
    input  logic [PW-2:0]         prog_addr,
    input  logic [INST_LEN-1:0]   prog_data,
    input  logic [ADDR_LEN-1:0]   dbg_addr,
    output logic [DATA_LEN-1:0]   dbg_data,
    output logic [PW-1:0]         pc,
    output logic [1:0]            state,
    output logic [1:0]            exec_code,
    output logic                  halted,
    output logic [DATA_LEN-1:0]   tos,
    output logic [CW-1:0]         stk_count
);

    typedef enum logic [1:0] {
        RETIRE = 2'b00,
        FETCH  = 2'b01,
        EXEC   = 2'b10
    } state_e;

    localparam logic [3:0] OP_HALT  = 4'h0;
    localparam logic [3:0] OP_PUSHC = 4'h1;
    localparam logic [3:0] OP_PUSH  = 4'h2;
    localparam logic [3:0] OP_POP   = 4'h3;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_SUB   = 4'h5;
    localparam logic [3:0] OP_AND   = 4'h6;
    localparam logic [3:0] OP_OR    = 4'h7;
    localparam logic [3:0] OP_NOT   = 4'h8;
    localparam logic [3:0] OP_JMP   = 4'h9;
    localparam logic [3:0] OP_JZ    = 4'hA;

    state_e                state_q, state_d;
    logic [PW-1:0]         pc_q, pc_d;
    logic [INST_LEN-1:0]   ir_q, ir_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            code_q, code_d;
    logic [DATA_LEN-1:0]   stack_q [STACK_DEPTH];
    logic [DATA_LEN-1:0]   stack_d [STACK_DEPTH];

    // Program store and data memory carry no reset.
    logic [INST_LEN-1:0]   rom_q [INST_CAP];
    logic [DATA_LEN-1:0]   mem_q [MEM_SIZE];

    logic                  mem_we;
    logic [ADDR_LEN-1:0]   mem_wa;
    logic [DATA_LEN-1:0]   mem_wd;

    logic [3:0]            op;
    logic [7:0]            opnd;
    logic [SW-1:0]         push_idx, top_idx, sec_idx;
    logic [DATA_LEN-1:0]   top_val, sec_val;
    logic [PW-1:0]         pc_inc;
    logic                  full, empty;

    assign op       = ir_q[INST_LEN-1:8];
    assign opnd     = ir_q[7:0];
    assign push_idx = cnt_q[SW-1:0];
    assign top_idx  = cnt_q[SW-1:0] - SW'(1);
    assign sec_idx  = cnt_q[SW-1:0] - SW'(2);
    assign top_val  = stack_q[top_idx];
    assign sec_val  = stack_q[sec_idx];
    assign pc_inc   = pc_q + PW'(1);
    assign full     = (cnt_q == CW'(STACK_DEPTH));
    assign empty    = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        stack_d = stack_q;
        mem_we  = 1'b0;
        mem_wa  = opnd[ADDR_LEN-1:0];
        mem_wd  = top_val;
        case (state_q)
            FETCH: begin
                state_d = EXEC;
                // Out-of-range fetch reads as HALT.
                ir_d = (pc_q < PW'(INST_CAP)) ? rom_q[pc_q[PW-2:0]] : '0;
            end
            EXEC: begin
                state_d = RETIRE;
                case (op)
                    OP_HALT: code_d = 2'b11;
                    OP_PUSHC, OP_PUSH: begin
                        if (full) begin
                            code_d = 2'b01;
                        end else begin
                            stack_d[push_idx] = (op == OP_PUSHC) ? DATA_LEN'(opnd)
                                                                 : mem_q[opnd[ADDR_LEN-1:0]];
                            cnt_d = cnt_q + CW'(1);
                            pc_d  = pc_inc;
                        end
                    end
                    OP_POP: begin
                        if (empty) begin
                            code_d = 2'b10;
                        end else begin
                            mem_we = 1'b1;
                            cnt_d  = cnt_q - CW'(1);
                            pc_d   = pc_inc;
                        end
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        if (cnt_q < CW'(2)) begin
                            code_d = 2'b10;
                        end else begin
                            case (op)
                                OP_ADD:  stack_d[sec_idx] = sec_val + top_val;
                                OP_SUB:  stack_d[sec_idx] = sec_val - top_val;
                                OP_AND:  stack_d[sec_idx] = sec_val & top_val;
                                default: stack_d[sec_idx] = sec_val | top_val;
                            endcase
                            cnt_d = cnt_q - CW'(1);
                            pc_d  = pc_inc;
                        end
                    end
                    OP_NOT: begin
                        if (empty) begin
                            code_d = 2'b10;
                        end else begin
                            stack_d[top_idx] = ~top_val;
                            pc_d = pc_inc;
                        end
                    end
                    OP_JMP: pc_d = opnd[PW-1:0];
                    OP_JZ: begin
                        if (empty) begin
                            code_d = 2'b10;
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                            pc_d  = (top_val == '0) ? opnd[PW-1:0] : pc_inc;
                        end
                    end
                    default: pc_d = pc_inc;
                endcase
            end
            RETIRE: begin
                if (code_q == 2'b00) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
            code_q  <= 2'b00;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            stack_q <= stack_d;
        end
    end

    always_ff @(posedge clk) begin
        if (prog_we && ({1'b0, prog_addr} < PW'(INST_CAP))) rom_q[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    assign dbg_data  = mem_q[dbg_addr];
    assign pc        = pc_q;
    assign state     = state_q;
    assign exec_code = code_q;
    assign halted    = (code_q != 2'b00);
    assign tos       = empty ? '0 : top_val;
    assign stk_count = cnt_q;

endmodule

// File: tb/tb_stack_cpu_core.sv
// Directed bench for stack_cpu_core: loads small programs, runs them and checks the visible state against hand-computed values.
module tb_stack_cpu_core;

    logic        clk = 1'b0;
    logic        rstn;
    logic        prog_we;
    logic [4:0]  prog_addr;
    logic [11:0] prog_data;
    logic [7:0]  dbg_addr;
    logic [7:0]  dbg_data;
    logic [5:0]  pc;
    logic [1:0]  state;
    logic [1:0]  exec_code;
    logic        halted;
    logic [7:0]  tos;
    logic [3:0]  stk_count;

    int n_pass  = 0;
    int n_total = 0;
    int ncyc;

    logic [11:0] prog [20];

    always #5 clk = ~clk;

    stack_cpu_core dut (
        .clk       (clk),
        .rstn      (rstn),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .pc        (pc),
        .state     (state),
        .exec_code (exec_code),
        .halted    (halted),
        .tos       (tos),
        .stk_count (stk_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 20; i++) prog[i] = 12'h000;
    endtask

    // Holds the core in reset, writes all 20 entries plus one ignored out-of-range write, then releases reset.
    task automatic load_and_start();
        rstn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            prog_we   = 1'b1;
            prog_addr = 5'(i);
            prog_data = prog[i];
        end
        @(negedge clk);
        prog_addr = 5'd25;
        prog_data = 12'h101;
        @(negedge clk);
        prog_we = 1'b0;
        rstn    = 1'b1;
    endtask

    task automatic run_until_halt(input string tag, input int max_cyc, output int n);
        n = 0;
        while (!halted && n < max_cyc) begin
            step(1);
            n++;
        end
        check({tag, " halt_reached"}, 32'(halted), 32'd1);
    endtask

    initial begin
        rstn = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; dbg_addr = '0;
        #12;
        check("rst state", 32'(state), 32'h1);
        check("rst pc", 32'(pc), 32'd0);
        check("rst cnt", 32'(stk_count), 32'd0);
        check("rst tos", 32'(tos), 32'd0);
        check("rst code", 32'(exec_code), 32'd0);
        check("rst halted", 32'(halted), 32'd0);

        // PUSHC 5, PUSHC 3, ADD, POP 0x10, HALT
        clear_prog();
        prog[0] = 12'h105; prog[1] = 12'h103; prog[2] = 12'h400; prog[3] = 12'h310;
        load_and_start();
        step(1);
        check("p1 e1 state", 32'(state), 32'h2);
        check("p1 e1 cnt", 32'(stk_count), 32'd0);
        step(1);
        check("p1 e2 tos", 32'(tos), 32'h05);
        check("p1 e2 cnt", 32'(stk_count), 32'd1);
        check("p1 e2 pc", 32'(pc), 32'd1);
        step(11);
        check("p1 e13 halted", 32'(halted), 32'd0);
        step(1);
        dbg_addr = 8'h10;
        #1;
        check("p1 halted", 32'(halted), 32'd1);
        check("p1 code", 32'(exec_code), 32'h3);
        check("p1 pc", 32'(pc), 32'd4);
        check("p1 cnt", 32'(stk_count), 32'd0);
        check("p1 mem10", 32'(dbg_data), 32'h08);
        step(1);
        check("p1 e15 state", 32'(state), 32'h0);

        // PUSHC 3, PUSHC 5, SUB, HALT -> wraps to 0xFE
        clear_prog();
        prog[0] = 12'h103; prog[1] = 12'h105; prog[2] = 12'h500;
        load_and_start();
        step(11);
        check("p2 tos", 32'(tos), 32'hFE);
        check("p2 cnt", 32'(stk_count), 32'd1);
        check("p2 code", 32'(exec_code), 32'h3);

        // Nine pushes overflow the 8-deep stack
        clear_prog();
        for (int i = 0; i < 9; i++) prog[i] = 12'h101;
        load_and_start();
        step(25);
        check("p3 e25 code", 32'(exec_code), 32'h0);
        step(1);
        check("p3 code", 32'(exec_code), 32'h1);
        check("p3 cnt", 32'(stk_count), 32'd8);
        check("p3 pc", 32'(pc), 32'd8);
        check("p3 tos", 32'(tos), 32'h01);
        step(20);
        check("p3 park state", 32'(state), 32'h0);
        check("p3 park pc", 32'(pc), 32'd8);

        // PUSHC 7, ADD -> underflow, stack untouched
        clear_prog();
        prog[0] = 12'h107; prog[1] = 12'h400;
        load_and_start();
        step(5);
        check("p4 code", 32'(exec_code), 32'h2);
        check("p4 tos", 32'(tos), 32'h07);
        check("p4 cnt", 32'(stk_count), 32'd1);
        check("p4 pc", 32'(pc), 32'd1);

        // Countdown from 3 in mem[0] using SUB/JZ/JMP
        clear_prog();
        prog[0] = 12'h103; prog[1] = 12'h300; prog[2] = 12'h200; prog[3] = 12'h101;
        prog[4] = 12'h500; prog[5] = 12'h300; prog[6] = 12'h200; prog[7] = 12'hA09;
        prog[8] = 12'h902;
        load_and_start();
        run_until_halt("p5", 200, ncyc);
        dbg_addr = 8'h00;
        #1;
        check("p5 cycles", 32'(ncyc), 32'd68);
        check("p5 mem0", 32'(dbg_data), 32'h00);
        check("p5 pc", 32'(pc), 32'd9);
        check("p5 code", 32'(exec_code), 32'h3);
        check("p5 cnt", 32'(stk_count), 32'd0);

        // Jump past the program store reads as HALT; the write to address 25 was dropped
        clear_prog();
        prog[0] = 12'h919;
        load_and_start();
        step(5);
        check("p6 code", 32'(exec_code), 32'h3);
        check("p6 pc", 32'(pc), 32'd25);
        check("p6 cnt", 32'(stk_count), 32'd0);

        // Reset pulse during EXEC, then rerun to completion
        clear_prog();
        prog[0] = 12'h106; prog[1] = 12'h103; prog[2] = 12'h400; prog[3] = 12'h310;
        load_and_start();
        step(4);
        check("p7 pre state", 32'(state), 32'h2);
        rstn = 1'b0;
        #1;
        check("p7 rst state", 32'(state), 32'h1);
        check("p7 rst pc", 32'(pc), 32'd0);
        check("p7 rst cnt", 32'(stk_count), 32'd0);
        check("p7 rst tos", 32'(tos), 32'd0);
        check("p7 rst halted", 32'(halted), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        run_until_halt("p7", 100, ncyc);
        dbg_addr = 8'h10;
        #1;
        check("p7 cycles", 32'(ncyc), 32'd14);
        check("p7 mem10", 32'(dbg_data), 32'h09);
        check("p7 pc", 32'(pc), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
